// File: rtl/md_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Funct codes, the md operation enum and the pending-result bundle.
package md_unit_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [3:0] {
        MD_NONE,
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MTHI,
        MD_MTLO,
        MD_MFHI,
        MD_MFLO
    } md_op_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
    } md_res_t;

    function automatic logic is_md_start(input md_op_t op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/md_decode.sv
// Instruction -> md operation decode.
// Shared with the hazard unit for its D-stage md-class check.
module md_decode
    import md_unit_pkg::*;
(
    input  logic [31:0] instr,
    output md_op_t      op
);

    logic [5:0] funct;
    logic       rtype;
    logic       unused_fields;

    assign funct         = instr[5:0];
    assign rtype         = (instr[31:26] == OP_SPECIAL);
    assign unused_fields = ^instr[25:6];

    always_comb begin
        op = MD_NONE;
        if (rtype) begin
            unique case (funct)
                FUNCT_MFHI:  op = MD_MFHI;
                FUNCT_MTHI:  op = MD_MTHI;
                FUNCT_MFLO:  op = MD_MFLO;
                FUNCT_MTLO:  op = MD_MTLO;
                FUNCT_MULT:  op = MD_MULT;
                FUNCT_MULTU: op = MD_MULTU;
                FUNCT_DIV:   op = MD_DIV;
                FUNCT_DIVU:  op = MD_DIVU;
                default:     op = MD_NONE;
            endcase
        end
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding the HI/LO registers.
// Result is computed at the start edge and retired after a fixed latency.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [31:0] InstrE,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HiLoOutE,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_op_t          op;
    md_res_t         res;
    md_res_t         pend;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_ld;
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [32:0] sq;
    logic signed [32:0] sr;
    logic [31:0]     uq;
    logic [31:0]     ur;
    logic            bzero;
    logic            unused_div;

    md_decode u_dec (
        .instr (InstrE),
        .op    (op)
    );

    assign Start = is_md_start(op) & ~Busy;

    assign HiLoOutE = (op == MD_MFHI) ? HI :
                      (op == MD_MFLO) ? LO : 32'h0;

    // 33-bit signed divide keeps 0x80000000 / -1 from overflowing
    assign sa    = {SrcAE[31], SrcAE};
    assign sb    = {SrcBE[31], SrcBE};
    assign bzero = (SrcBE == 32'h0);
    assign sq    = bzero ? 33'sd0 : sa / sb;
    assign sr    = bzero ? 33'sd0 : sa % sb;
    assign uq    = bzero ? 32'h0 : SrcAE / SrcBE;
    assign ur    = bzero ? 32'h0 : SrcAE % SrcBE;

    assign prod_s = $signed({{32{SrcAE[31]}}, SrcAE}) *
                    $signed({{32{SrcBE[31]}}, SrcBE});
    assign prod_u = {32'h0, SrcAE} * {32'h0, SrcBE};

    assign unused_div = sq[32] ^ sr[32];

    always_comb begin
        res    = '0;
        cnt_ld = CW'(MULT_CYCLES);
        case (op)
            MD_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], we: 1'b1};
            MD_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], we: 1'b1};
            MD_DIV: begin
                res    = '{hi: sr[31:0], lo: sq[31:0], we: ~bzero};
                cnt_ld = CW'(DIV_CYCLES);
            end
            MD_DIVU: begin
                res    = '{hi: ur, lo: uq, we: ~bzero};
                cnt_ld = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI   <= '0;
            LO   <= '0;
            Busy <= 1'b0;
            cnt  <= '0;
            pend <= '0;
        end else if (Start) begin
            pend <= res;
            cnt  <= cnt_ld;
            Busy <= 1'b1;
        end else if (Busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                Busy <= 1'b0;
                if (pend.we) begin
                    HI <= pend.hi;
                    LO <= pend.lo;
                end
            end
        end else if (op == MD_MTHI) begin
            HI <= SrcAE;
        end else if (op == MD_MTLO) begin
            LO <= SrcAE;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Expected HI/LO pairs are queued at issue and popped at retire.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] InstrE;
    logic        Start;
    logic        Busy;
    logic [31:0] HiLoOutE;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    localparam logic [31:0] NOP = 32'h0000_0020;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .InstrE   (InstrE),
        .Start    (Start),
        .Busy     (Busy),
        .HiLoOutE (HiLoOutE),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] rinst(input logic [5:0] f);
        return {26'h0, f};
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        InstrE = rinst(f);
        SrcAE  = a;
        SrcBE  = b;
        #1;
        check({tag, "_start"}, Start, 1);
        sb.push_back({eh, el});
        tick();
        InstrE = NOP;
    endtask

    task automatic retire(input string tag, input int n);
        int c = 0;
        while (Busy && c < 200) begin
            c++;
            tick();
        end
        check({tag, "_busy_cycles"}, c, n);
        check({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() != 0) check({tag, "_hilo"}, {HI, LO}, sb.pop_front());
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh,
                             input logic [31:0] el);
        InstrE = rinst(FUNCT_MFLO);
        #1;
        check({tag, "_mflo"}, HiLoOutE, el);
        InstrE = rinst(FUNCT_MFHI);
        #1;
        check({tag, "_mfhi"}, HiLoOutE, eh);
        InstrE = NOP;
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        longint unsigned p;
        reset  = 1'b1;
        SrcAE  = '0;
        SrcBE  = '0;
        InstrE = NOP;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", Busy, 0);
        check("rst_start", Start, 0);
        check("nop_hilo_out", HiLoOutE, 0);

        issue("mult", FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("mult_start_drop", Start, 0);
        retire("mult", 5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue("multu", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        retire("multu", 5);

        issue("div", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        retire("div", 10);

        issue("divu0", FUNCT_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        retire("divu0", 10);

        issue("divovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        retire("divovf", 10);

        InstrE = rinst(FUNCT_MTHI);
        SrcAE  = 32'h1234_5678;
        sb.push_back({32'h1234_5678, LO});
        tick();
        InstrE = NOP;
        check("mthi", {HI, LO}, sb.pop_front());
        InstrE = rinst(FUNCT_MTLO);
        SrcAE  = 32'h9ABC_DEF0;
        sb.push_back({HI, 32'h9ABC_DEF0});
        tick();
        InstrE = NOP;
        check("mtlo", {HI, LO}, sb.pop_front());
        read_hilo("mtx", 32'h1234_5678, 32'h9ABC_DEF0);

        issue("mult23", FUNCT_MULT, 32'd2, 32'd3, 32'h0, 32'h6);
        InstrE = rinst(FUNCT_MTHI);
        SrcAE  = 32'hDEAD_BEEF;
        #1;
        check("mthi_busy_start", Start, 0);
        tick();
        InstrE = rinst(FUNCT_MULT);
        SrcAE  = 32'd7;
        SrcBE  = 32'd7;
        #1;
        check("mult_busy_start", Start, 0);
        retire("mult23", 4);
        check("b2b_start", Start, 1);
        sb.push_back({32'h0, 32'd49});
        tick();
        InstrE = NOP;
        retire("b2b", 5);

        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            p = longint'(a) * longint'(b);
            issue("rmultu", FUNCT_MULTU, a, b, p[63:32], p[31:0]);
            retire("rmultu", 5);
            b = $urandom_range(1, 1000);
            issue("rdivu", FUNCT_DIVU, a, b, a % b, a / b);
            retire("rdivu", 10);
        end

        InstrE = rinst(FUNCT_DIV);
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        tick();
        InstrE = NOP;
        tick();
        tick();
        check("rst_mid_busy_pre", Busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_hilo", {HI, LO}, 64'h0);
        repeat (12) tick();
        check("rst_mid_late_hilo", {HI, LO}, 64'h0);
        check("rst_mid_late_busy", Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
